// File: rtl/nabu_ce_gen.sv
// Multi-channel fractional clock-enable generator: per-channel phase accumulators
// emitting paired positive/negative-phase one-cycle enables with boundary-aligned rate changes.
module nabu_ce_gen #(
    parameter int CHANNELS = 4,
    parameter int ACC_W = 16,
    parameter logic [CHANNELS*ACC_W-1:0] INIT_INC = {4{16'h0800}}
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [CHANNELS*ACC_W-1:0] inc_in,
    input  logic [CHANNELS-1:0]       inc_load,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       hold,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       ce_p,
    output logic [CHANNELS-1:0]       ce_n,
    output logic [CHANNELS-1:0]       pending
);

    localparam logic [ACC_W-1:0] INC_MAX = {1'b1, {(ACC_W-1){1'b0}}};

    // Limiting the increment to half scale keeps ce_p and ce_n from ever coinciding.
    function automatic logic [ACC_W-1:0] clamp_inc(input logic [ACC_W-1:0] v);
        if (v > INC_MAX) begin
            clamp_inc = INC_MAX;
        end else begin
            clamp_inc = v;
        end
    endfunction

    logic [CHANNELS-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [CHANNELS-1:0][ACC_W-1:0] inc_act_q, inc_act_d;
    logic [CHANNELS-1:0][ACC_W-1:0] inc_sh_q, inc_sh_d;
    logic [CHANNELS-1:0]            pend_q, pend_d;
    logic [CHANNELS-1:0]            ce_p_q, ce_p_d;
    logic [CHANNELS-1:0]            ce_n_q, ce_n_d;

    logic [CHANNELS-1:0][ACC_W:0]   sum_s;
    logic [CHANNELS-1:0]            step_s;
    logic [CHANNELS-1:0]            fire_s;
    logic [CHANNELS-1:0]            apply_s;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign sum_s[g]   = {1'b0, acc_q[g]} + {1'b0, inc_act_q[g]};
        assign step_s[g]  = en[g] & ~hold[g] & ~sync;
        assign fire_s[g]  = step_s[g] & sum_s[g][ACC_W];
        // The shadow is only taken at a period boundary or when the channel is idle.
        assign apply_s[g] = pend_q[g] & (sync | ~en[g] | (inc_act_q[g] == {ACC_W{1'b0}}) | fire_s[g]);
    end

    // Next-state logic for accumulators, increments and enable pulses.
    always_comb begin
        acc_d     = acc_q;
        inc_act_d = inc_act_q;
        inc_sh_d  = inc_sh_q;
        pend_d    = pend_q;
        ce_p_d    = {CHANNELS{1'b0}};
        ce_n_d    = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            if (sync) begin
                acc_d[c] = {ACC_W{1'b0}};
            end else if (step_s[c]) begin
                acc_d[c]  = sum_s[c][ACC_W-1:0];
                ce_p_d[c] = sum_s[c][ACC_W];
                ce_n_d[c] = ~acc_q[c][ACC_W-1] & sum_s[c][ACC_W-1] & ~sum_s[c][ACC_W];
            end else begin
                acc_d[c] = acc_q[c];
            end

            if (apply_s[c]) begin
                inc_act_d[c] = inc_sh_q[c];
                pend_d[c]    = 1'b0;
            end else begin
                inc_act_d[c] = inc_act_q[c];
            end

            // A load on the apply edge re-arms the shadow with the new value.
            if (inc_load[c]) begin
                inc_sh_d[c] = clamp_inc(inc_in[c*ACC_W +: ACC_W]);
                pend_d[c]   = 1'b1;
            end else begin
                inc_sh_d[c] = inc_sh_q[c];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c]     <= {ACC_W{1'b0}};
                inc_act_q[c] <= clamp_inc(INIT_INC[c*ACC_W +: ACC_W]);
                inc_sh_q[c]  <= {ACC_W{1'b0}};
            end
            pend_q <= {CHANNELS{1'b0}};
            ce_p_q <= {CHANNELS{1'b0}};
            ce_n_q <= {CHANNELS{1'b0}};
        end else begin
            acc_q     <= acc_d;
            inc_act_q <= inc_act_d;
            inc_sh_q  <= inc_sh_d;
            pend_q    <= pend_d;
            ce_p_q    <= ce_p_d;
            ce_n_q    <= ce_n_d;
        end
    end

    assign ce_p    = ce_p_q;
    assign ce_n    = ce_n_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_nabu_ce_gen.sv
// Directed bench for nabu_ce_gen: enable timing, clamp, rate switch, hold, sync and reset.
module tb_nabu_ce_gen;

    logic        clk_sys;
    logic        reset_n;
    logic [63:0] inc_in;
    logic [3:0]  inc_load;
    logic [3:0]  en;
    logic [3:0]  hold;
    logic        sync;
    logic [3:0]  ce_p;
    logic [3:0]  ce_n;
    logic [3:0]  pending;

    int vectors;
    int errs;
    int e;

    nabu_ce_gen #(
        .CHANNELS(4),
        .ACC_W(16),
        .INIT_INC({16'h0000, 16'h1000, 16'h0800, 16'h4000})
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .inc_in  (inc_in),
        .inc_load(inc_load),
        .en      (en),
        .hold    (hold),
        .sync    (sync),
        .ce_p    (ce_p),
        .ce_n    (ce_n),
        .pending (pending)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s at edge %0d: observed %h expected %h", tag, e, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        e++;
    endtask

    initial begin
        logic [3:0] xp;
        logic [3:0] xn;
        logic [3:0] xpend;
        int cnt;
        int bad;
        int both;
        int last;
        int first;
        int base;
        int r;

        vectors  = 0;
        errs     = 0;
        e        = 0;
        reset_n  = 1'b0;
        inc_in   = 64'h0;
        inc_load = 4'h0;
        en       = 4'hF;
        hold     = 4'h0;
        sync     = 1'b0;

        // Reset state
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1;
        chk("rst_ce_p", ce_p, 4'h0);
        chk("rst_ce_n", ce_n, 4'h0);
        chk("rst_pending", pending, 4'h0);
        #2;
        reset_n = 1'b1;
        e = 0;

        // Phase 1: ch0 0x4000 then clamped 0x9000, ch1 0x0800->0x0600, ch2 hold, ch3 stopped
        for (int i = 0; i < 107; i++) begin
            inc_load = 4'h0;
            if (e + 1 == 13) begin
                inc_in[15:0] = 16'h9000;
                inc_load[0]  = 1'b1;
            end
            if (e + 1 == 40) begin
                inc_in[31:16] = 16'h0600;
                inc_load[1]   = 1'b1;
            end
            hold[2] = (e + 1 >= 50) && (e + 1 <= 54);
            tick();
            xp[0] = (e <= 16) ? (e % 4 == 0) : (e % 2 == 0);
            xn[0] = (e <= 16) ? (e % 4 == 2) : (e % 2 == 1);
            xp[1] = (e <= 64) ? (e % 32 == 0)  : (e == 107);
            xn[1] = (e <= 64) ? (e % 32 == 16) : (e == 86);
            xp[2] = (e == 16) || (e == 32) || (e == 48) || (e == 69) || (e == 85) || (e == 101);
            xn[2] = (e == 8) || (e == 24) || (e == 40) || (e == 61) || (e == 77) || (e == 93);
            xp[3] = 1'b0;
            xn[3] = 1'b0;
            xpend = {2'b00, (e >= 40 && e <= 63), (e >= 13 && e <= 15)};
            chk("p1_ce_p", ce_p, xp);
            chk("p1_ce_n", ce_n, xn);
            chk("p1_pending", pending, xpend);
        end
        inc_load = 4'h0;
        hold     = 4'h0;

        // Phase 2: ch3 leaves the stop state at 0x5555 and runs a full 2^16-cycle window
        inc_in[63:48] = 16'h5555;
        inc_load      = 4'h8;
        tick();
        inc_load = 4'h0;
        chk("p2_pend_set", pending, 4'h8);
        tick();
        chk("p2_pend_clr", pending, 4'h0);
        cnt   = 0;
        bad   = 0;
        both  = 0;
        last  = e;
        first = 0;
        for (int i = 0; i < 65536; i++) begin
            tick();
            if ((ce_p & ce_n) != 4'h0) both++;
            if (ce_p[3]) begin
                cnt++;
                if ((e - last != 3) && (e - last != 4)) bad++;
                if (first == 0) first = e;
                last = e;
            end
        end
        chk("p2_pulse_count", cnt, 21845);
        chk("p2_bad_intervals", bad, 0);
        chk("p2_coincident", both, 0);
        chk("p2_first_pulse", first - 109, 4);

        // Phase 3: pending ch0 load, then sync together with hold on ch2
        inc_in[15:0] = 16'h4000;
        inc_load     = 4'h1;
        tick();
        inc_load = 4'h0;
        chk("p3_pend_set", pending, 4'h1);
        sync = 1'b1;
        hold = 4'h4;
        tick();
        sync = 1'b0;
        hold = 4'h0;
        chk("p3_sync_ce_p", ce_p, 4'h0);
        chk("p3_sync_ce_n", ce_n, 4'h0);
        chk("p3_sync_pend", pending, 4'h0);
        base = e;
        for (int i = 0; i < 44; i++) begin
            tick();
            r = e - base;
            xp[0] = (r % 4 == 0);
            xn[0] = (r % 4 == 2);
            xp[1] = (r == 43);
            xn[1] = (r == 22);
            xp[2] = (r % 16 == 0);
            xn[2] = (r % 16 == 8);
            chk("p3_ce_p", ce_p[2:0], xp[2:0]);
            chk("p3_ce_n", ce_n[2:0], xn[2:0]);
        end

        // Phase 4: asynchronous reset mid-period with a load pending
        inc_in[31:16] = 16'h0123;
        inc_load      = 4'h2;
        tick();
        inc_load = 4'h0;
        chk("p4_pend_set", pending, 4'h2);
        tick();
        chk("p4_ce_n0_pre", ce_n[0], 1'b1);
        chk("p4_pend_pre", pending, 4'h2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("p4_async_ce_p", ce_p, 4'h0);
        chk("p4_async_ce_n", ce_n, 4'h0);
        chk("p4_async_pend", pending, 4'h0);
        @(posedge clk_sys);
        #1;
        chk("p4_held_ce_n", ce_n, 4'h0);
        #2;
        reset_n = 1'b1;
        e = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            xp = {1'b0, (e % 16 == 0), (e == 32), (e % 4 == 0)};
            xn = {1'b0, (e % 16 == 8), (e == 16), (e % 4 == 2)};
            chk("p4_ce_p", ce_p, xp);
            chk("p4_ce_n", ce_n, xn);
            chk("p4_pending", pending, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
